// File: rtl/alu_shl_7bit_seq_pkg.sv
// Shared ALU package: widths and the shifter FSM state encoding.
// Imported by the ALU function units and their bus interface.
package alu_shl_7bit_seq_pkg;

  localparam int ALU_W   = 7;
  localparam int ALU_SHW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_st_e;

endpackage

// File: rtl/alu_shl_7bit_seq_if.sv
// Start/ready bus between the ALU sequencer and the left shifter.
// master: start/in/shift out, status in. slave: the reverse.
interface alu_shl_7bit_seq_if
  import alu_shl_7bit_seq_pkg::*;
#(
  parameter int W  = ALU_W,
  parameter int SW = ALU_SHW
);

  logic          start;
  logic [W-1:0]  in;
  logic [SW-1:0] shift;
  logic          ready;
  logic          done;
  logic [W-1:0]  out;
  logic          carry;
  logic          zero;

  modport master (
    output start,
    output in,
    output shift,
    input  ready,
    input  done,
    input  out,
    input  carry,
    input  zero
  );

  modport slave (
    input  start,
    input  in,
    input  shift,
    output ready,
    output done,
    output out,
    output carry,
    output zero
  );

endinterface

// File: rtl/alu_shl_7bit_seq.sv
// Sequential 7-bit logical shift-left, one bit per clock.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module alu_shl_7bit_seq
  import alu_shl_7bit_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_shl_7bit_seq_if.slave bus
);

  alu_st_e             state_q;
  alu_st_e             state_d;
  logic [ALU_W-1:0]    sreg_q;
  logic [ALU_W-1:0]    sreg_d;
  logic [ALU_SHW-1:0]  cnt_q;
  logic [ALU_SHW-1:0]  cnt_d;
  logic                carry_q;
  logic                carry_d;

  logic                accept;
  logic                last;

  assign accept = (state_q == ST_IDLE) && bus.start;
  assign last   = (cnt_q == ALU_SHW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.shift == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    if (accept) begin
      sreg_d  = bus.in;
      cnt_d   = bus.shift;
      carry_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      // msb leaves as carry; the last one out is what remains
      sreg_d  = {sreg_q[ALU_W-2:0], 1'b0};
      carry_d = sreg_q[ALU_W-1];
      cnt_d   = cnt_q - ALU_SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.out   = sreg_q;
  assign bus.carry = carry_q;
  assign bus.zero  = (sreg_q == '0);

endmodule

// File: tb/tb_alu_shl_7bit_seq.sv
// Directed bench for alu_shl_7bit_seq.
// Inputs change and outputs sample 1ns after each rising edge.
module tb_alu_shl_7bit_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_shl_7bit_seq_if bus ();

  alu_shl_7bit_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag,
                        input logic [6:0] a,
                        input logic [2:0] s,
                        input logic [6:0] eo,
                        input logic ec,
                        input logic ez,
                        input int elat);
    int lat;
    bus.in    = a;
    bus.shift = s;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_out"}, 32'(bus.out), 32'(eo));
    chk({tag, "_carry"}, 32'(bus.carry), 32'(ec));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(ez));
    chk({tag, "_rdy_in_done"}, 32'(bus.ready), 32'(0));
    step();
    chk({tag, "_done_1cyc"}, 32'(bus.done), 32'(0));
    chk({tag, "_rdy_after"}, 32'(bus.ready), 32'(1));
    chk({tag, "_out_hold"}, 32'(bus.out), 32'(eo));
  endtask

  initial begin
    int lat;
    int nd;
    int last_i;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    bus.shift = '0;
    step();
    step();
    rst = 1'b0;

    chk("rst_ready", 32'(bus.ready), 32'(1));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_out", 32'(bus.out), 32'(0));
    chk("rst_carry", 32'(bus.carry), 32'(0));
    chk("rst_zero", 32'(bus.zero), 32'(1));

    run_op("v59s3", 7'b1011001, 3'd3, 7'b1001000, 1'b1, 1'b0, 4);
    run_op("v2As0", 7'h2A, 3'd0, 7'h2A, 1'b0, 1'b0, 1);
    run_op("v7Fs7", 7'h7F, 3'd7, 7'h00, 1'b1, 1'b1, 8);
    run_op("v40s1", 7'h40, 3'd1, 7'h00, 1'b1, 1'b1, 2);
    run_op("v15s2", 7'h15, 3'd2, 7'h54, 1'b0, 1'b0, 3);

    // start pulse during SHIFT must be ignored
    bus.in    = 7'h01;
    bus.shift = 3'd2;
    bus.start = 1'b1;
    step();
    bus.in    = 7'h7F;
    bus.shift = 3'd1;
    bus.start = 1'b1;
    chk("ign_rdy_a", 32'(bus.ready), 32'(0));
    step();
    bus.start = 1'b0;
    chk("ign_rdy_b", 32'(bus.ready), 32'(0));
    lat = 2;
    while (!bus.done && lat < 20) begin
      step();
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'(3));
    chk("ign_out", 32'(bus.out), 32'(7'h04));
    chk("ign_carry", 32'(bus.carry), 32'(0));
    step();
    chk("ign_rdy_idle", 32'(bus.ready), 32'(1));

    // reset mid-SHIFT discards the op
    bus.in    = 7'h03;
    bus.shift = 3'd5;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("mid_rdy_busy", 32'(bus.ready), 32'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_ready", 32'(bus.ready), 32'(1));
    chk("mid_out", 32'(bus.out), 32'(0));
    chk("mid_zero", 32'(bus.zero), 32'(1));
    chk("mid_carry", 32'(bus.carry), 32'(0));
    chk("mid_done", 32'(bus.done), 32'(0));
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) nd++;
    end
    chk("mid_no_done", 32'(nd), 32'(0));
    chk("mid_still_idle", 32'(bus.ready), 32'(1));

    // start held high: one op per 3 cycles
    bus.in    = 7'h41;
    bus.shift = 3'd1;
    bus.start = 1'b1;
    nd = 0;
    last_i = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) begin
        nd++;
        chk("b2b_out", 32'(bus.out), 32'(7'h02));
        chk("b2b_carry", 32'(bus.carry), 32'(1));
        chk("b2b_rdy", 32'(bus.ready), 32'(0));
        if (last_i >= 0) begin
          chk("b2b_period", 32'(i - last_i), 32'(3));
        end else begin
          chk("b2b_first", 32'(i), 32'(1));
        end
        last_i = i;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 32'(nd), 32'(4));
    step();
    step();
    chk("b2b_idle", 32'(bus.ready), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
